// File: rtl/dmem_responder_pkg.sv
// Shared core-wide definitions for the data-memory path.
//   - SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (funct3[1:0])
//   - state_t             : responder FSM states
//   - lane_mask()         : byte-lane enable mask for a size at a byte offset
package dmem_responder_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Lanes start at the byte offset and span 1/2/4/8 bytes. Only meaningful
    // for aligned accesses; misaligned ones are rejected before use.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_responder_load_align_ext.sv
// Load alignment and extension (combinational).
// Ports:
//   word        : 64-bit storage word containing the access
//   offset      : byte offset of the access inside the word (addr[2:0])
//   size        : access size, SZ_B/SZ_H/SZ_W/SZ_D
//   is_unsigned : zero-extend when 1, sign-extend when 0 (ignored for SZ_D)
//   data        : right-aligned, extended load value
module load_align_ext
    import dmem_responder_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B:    data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            SZ_W:    data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for a stall-capable core.
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the response transfers on an edge where resp_valid and
// resp_ready are both 1. A valid side holds its payload until the transfer.
// Only one request is outstanding at a time.
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   req_valid / req_ready      : request channel handshake
//   req_write                  : 1 = store, 0 = load
//   req_addr                   : byte address
//   req_wdata                  : right-aligned store data
//   req_size, req_unsigned     : access size and load zero-extension
//   resp_valid / resp_ready    : response channel handshake
//   resp_rdata                 : extended load data, 0 for stores and errors
//   resp_error                 : misaligned or out-of-range access
//   dbg_state                  : current FSM state
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output state_t      dbg_state
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] BYTE_CAP  = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [63:0] mem [DEPTH_WORDS];

    // Operation seen on the edge entering RESP. With no wait states that edge
    // is also the capture edge, so the live request is used directly.
    logic             op_write;
    logic [63:0]      op_addr;
    logic [63:0]      op_wdata;
    logic [1:0]       op_size;
    logic             op_unsigned;
    logic             op_error;
    logic [IDX_W-1:0] op_idx;
    logic [63:0]      op_word;
    logic [63:0]      load_data;
    logic [7:0]       byte_mask;
    logic [63:0]      bit_mask;
    logic [63:0]      store_data;
    logic [63:0]      merged;
    logic             enter_resp;

    // Full 64-bit range compare so high address bits cannot alias into storage.
    function automatic logic access_error(input logic [63:0] addr,
                                          input logic [1:0]  size);
        logic misaligned;
        case (size)
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            SZ_D:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
        return misaligned || (addr >= BYTE_CAP);
    endfunction

    always_comb begin
        if (ZERO_WAIT) begin
            op_write    = req_write;
            op_addr     = req_addr;
            op_wdata    = req_wdata;
            op_size     = req_size;
            op_unsigned = req_unsigned;
        end else begin
            op_write    = cap_write;
            op_addr     = cap_addr;
            op_wdata    = cap_wdata;
            op_size     = cap_size;
            op_unsigned = cap_unsigned;
        end
        op_error   = access_error(op_addr, op_size);
        op_idx     = op_addr[IDX_W+2:3];
        op_word    = mem[op_idx];
        byte_mask  = lane_mask(op_size, op_addr[2:0]);
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        store_data = op_wdata << {op_addr[2:0], 3'b000};
        merged     = (op_word & ~bit_mask) | (store_data & bit_mask);
    end

    always_comb begin
        case (state)
            IDLE:    enter_resp = ZERO_WAIT && req_valid;
            WAIT:    enter_resp = (cnt == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

    load_align_ext u_load_align_ext (
        .word        (op_word),
        .offset      (op_addr[2:0]),
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .data        (load_data)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            cnt          <= '0;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= SZ_B;
            cap_unsigned <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Store commit and load sampling share the edge entering RESP.
            if (enter_resp) begin
                resp_error <= op_error;
                resp_rdata <= (op_error || op_write) ? 64'd0 : load_data;
                if (op_write && !op_error) begin
                    mem[op_idx] <= merged;
                end
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        req_ready    <= 1'b0;
                        if (ZERO_WAIT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready rises only after the response has left.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT with two wait states
    logic        a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
    logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [1:0]  a_req_size;
    logic        a_resp_valid, a_resp_ready, a_resp_error;
    state_t      a_dbg;

    // DUT with no wait states
    logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
    logic [63:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic [1:0]  z_req_size;
    logic        z_resp_valid, z_resp_ready, z_resp_error;
    state_t      z_dbg;

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_size(a_req_size),
        .req_unsigned(a_req_unsigned), .resp_valid(a_resp_valid),
        .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_error(a_resp_error), .dbg_state(a_dbg)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
        .req_unsigned(z_req_unsigned), .resp_valid(z_resp_valid),
        .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .resp_error(z_resp_error), .dbg_state(z_dbg)
    );

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    // ---------------- driver tasks ----------------
    // lat counts edges from the accepting edge (inclusive) to the edge after
    // which resp_valid is first seen high.
    task automatic a_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] size, input logic uns, input logic ack,
                            output logic [63:0] rdata, output logic err, output int lat);
        @(negedge clk);
        n_cmp++;
        if (a_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL a_ready_before_req: got %b want 1", a_req_ready);
        end
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
        a_req_size = size; a_req_unsigned = uns; a_resp_ready = ack;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 1;
        while (a_resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = a_resp_rdata;
        err   = a_resp_error;
        if (ack) begin
            @(posedge clk); #1;
            a_resp_ready = 1'b0;
        end
    endtask

    task automatic z_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] size, output logic [63:0] rdata,
                            output logic err, output int lat);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wdata;
        z_req_size = size; z_req_unsigned = 1'b0; z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        lat = 1;
        while (z_resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = z_resp_rdata;
        err   = z_resp_error;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", a_req_ready); end
        n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", a_resp_valid); end
        n_cmp++; if (a_resp_rdata !== 64'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", a_resp_rdata); end
        n_cmp++; if (a_resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", a_resp_error); end
        n_cmp++; if (a_dbg !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", a_dbg); end
        n_cmp++; if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_z_handshake: got ready=%b valid=%b want 1/0", z_req_ready, z_resp_valid);
        end
    endtask

    task automatic test_table(input string name, input vec_t v[$]);
        logic [63:0] d;
        logic        e;
        int          lat;
        foreach (v[i]) begin
            a_access(v[i].wr, v[i].addr, v[i].wdata, v[i].size, v[i].uns, 1'b1, d, e, lat);
            n_cmp++; if (d !== v[i].exp_data) begin n_bad++; $display("FAIL %s[%0d]_rdata: got %h want %h", name, i, d, v[i].exp_data); end
            n_cmp++; if (e !== v[i].exp_err) begin n_bad++; $display("FAIL %s[%0d]_error: got %b want %b", name, i, e, v[i].exp_err); end
            n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL %s[%0d]_latency: got %0d want 3", name, i, lat); end
        end
    endtask

    task automatic test_store_load();
        vec_t v[$];
        v.push_back('{1'b1, 64'h10, 64'h1122334455667788, SZ_D, 1'b0, 64'h0, 1'b0});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_D, 1'b0, 64'h1122334455667788, 1'b0});
        test_table("store_load", v);
    endtask

    task automatic test_lanes();
        vec_t v[$];
        v.push_back('{1'b0, 64'h17, 64'h0, SZ_B, 1'b0, 64'h0000000000000011, 1'b0});
        v.push_back('{1'b1, 64'h11, 64'h123456789ABCDE80, SZ_B, 1'b0, 64'h0, 1'b0});
        v.push_back('{1'b0, 64'h11, 64'h0, SZ_B, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0});
        v.push_back('{1'b0, 64'h11, 64'h0, SZ_B, 1'b1, 64'h0000000000000080, 1'b0});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_D, 1'b0, 64'h1122334455668088, 1'b0});
        v.push_back('{1'b0, 64'h16, 64'h0, SZ_H, 1'b1, 64'h0000000000001122, 1'b0});
        v.push_back('{1'b1, 64'h14, 64'hFFFFFFFFFFFFBEEF, SZ_H, 1'b0, 64'h0, 1'b0});
        v.push_back('{1'b0, 64'h14, 64'h0, SZ_H, 1'b0, 64'hFFFFFFFFFFFFBEEF, 1'b0});
        v.push_back('{1'b0, 64'h14, 64'h0, SZ_W, 1'b0, 64'h000000001122BEEF, 1'b0});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_W, 1'b1, 64'h0000000055668088, 1'b0});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_D, 1'b1, 64'h1122BEEF55668088, 1'b0});
        test_table("lanes", v);
    endtask

    task automatic test_errors();
        vec_t v[$];
        v.push_back('{1'b0, 64'h12, 64'h0, SZ_W, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b0, 64'h13, 64'h0, SZ_H, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b1, 64'h402, 64'h12345678, SZ_W, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b0, 64'h400, 64'h0, SZ_D, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b0, 64'h3F8, 64'h0, SZ_D, 1'b0, 64'h0, 1'b0});
        v.push_back('{1'b1, 64'h8000000000000010, 64'hFFFF, SZ_D, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b0, 64'h8000000000000010, 64'h0, SZ_B, 1'b0, 64'h0, 1'b1});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_D, 1'b0, 64'h1122BEEF55668088, 1'b0});
        test_table("errors", v);
    endtask

    task automatic test_hold();
        logic [63:0] d;
        logic        e;
        int          lat;
        a_access(1'b0, 64'h10, 64'h0, SZ_D, 1'b0, 1'b0, d, e, lat);
        n_cmp++; if (d !== 64'h1122BEEF55668088) begin n_bad++; $display("FAIL hold_first_rdata: got %h want 1122beef55668088", d); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (a_resp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, a_resp_valid); end
            n_cmp++; if (a_resp_rdata !== 64'h1122BEEF55668088) begin n_bad++; $display("FAIL hold_rdata[%0d]: got %h want 1122beef55668088", i, a_resp_rdata); end
            n_cmp++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, a_req_ready); end
        end
        @(negedge clk); a_resp_ready = 1'b1;
        @(posedge clk); #1; a_resp_ready = 1'b0;
        n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", a_resp_valid); end
        n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready: got %b want 1", a_req_ready); end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h20;
        a_req_wdata = 64'hDEAD; a_req_size = SZ_D; a_req_unsigned = 1'b0; a_resp_ready = 1'b1;
        @(posedge clk); #1; a_req_valid = 1'b0;
        n_cmp++; if (a_dbg !== WAIT) begin n_bad++; $display("FAIL mid_in_wait: got %0d want WAIT", a_dbg); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0; a_resp_ready = 1'b0;
        n_cmp++; if (a_dbg !== IDLE) begin n_bad++; $display("FAIL mid_state: got %0d want IDLE", a_dbg); end
        n_cmp++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_handshake: got ready=%b valid=%b want 1/0", a_req_ready, a_resp_valid);
        end
        n_cmp++; if (a_resp_rdata !== 64'd0 || a_resp_error !== 1'b0) begin
            n_bad++; $display("FAIL mid_outputs: got rdata=%h err=%b want 0/0", a_resp_rdata, a_resp_error);
        end
        v.push_back('{1'b0, 64'h20, 64'h0, SZ_D, 1'b0, 64'h0, 1'b0});
        v.push_back('{1'b0, 64'h10, 64'h0, SZ_D, 1'b0, 64'h0, 1'b0});
        test_table("after_reset", v);
    endtask

    task automatic test_zero_wait();
        logic [63:0] d;
        logic        e;
        int          lat;
        logic        acc;
        z_access(1'b1, 64'h08, 64'hCAFE, SZ_D, d, e, lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL z_store_latency: got %0d want 1", lat); end
        n_cmp++; if (d !== 64'd0 || e !== 1'b0) begin n_bad++; $display("FAIL z_store_resp: got %h/%b want 0/0", d, e); end
        z_access(1'b0, 64'h08, 64'h0, SZ_D, d, e, lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL z_load_latency: got %0d want 1", lat); end
        n_cmp++; if (d !== 64'hCAFE) begin n_bad++; $display("FAIL z_load_rdata: got %h want cafe", d); end
        // Continuous requests with the response always consumed.
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 64'h08; z_req_size = SZ_D;
        z_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = z_req_ready;
            @(posedge clk); #1;
            n_cmp++; if (acc !== (i % 2 == 0)) begin n_bad++; $display("FAIL b2b_accept[%0d]: got %b want %b", i, acc, (i % 2 == 0)); end
            n_cmp++; if (z_resp_valid !== (i % 2 == 0)) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, z_resp_valid, (i % 2 == 0)); end
            if (z_resp_valid === 1'b1) begin
                n_cmp++; if (z_resp_rdata !== 64'hCAFE) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want cafe", i, z_resp_rdata); end
            end
        end
        z_req_valid = 1'b0; z_resp_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_req_size = SZ_B; a_req_unsigned = 1'b0; a_resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_size = SZ_B; z_req_unsigned = 1'b0; z_resp_ready = 1'b0;

        test_reset();
        test_store_load();
        test_lanes();
        test_errors();
        test_hold();
        test_reset_mid();
        test_zero_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
